// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and default constants for the MEM-stage data
//               memory unit (FSM state encoding, default geometry/latency).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Load sequencer states: IDLE waits for work, BUSY counts stall cycles,
  // DONE is the single write-back cycle of a load.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int DEFAULT_DEPTH_WORDS  = 256;
  localparam int DEFAULT_LOAD_LATENCY = 2;

  // Wide enough for LOAD_LATENCY-2 with LOAD_LATENCY up to 7.
  localparam int CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Word-wide data RAM, synchronous write, asynchronous read.
//               Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Store port: one word written per rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_unit
// Description : MEM stage of a 5-stage pipeline: data RAM access, multi-cycle
//               load sequencing with pipeline stall, and the MEM/WB register.
//               Optional build macro ALIGN_CHECK_EN adds misalignment
//               detection (MisalignW output, misaligned stores dropped,
//               misaligned loads complete without stall and with RegWW=0).
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = DEFAULT_DEPTH_WORDS,
  parameter int LOAD_LATENCY = DEFAULT_LOAD_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWM,
  input  logic        MemToRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        StallM,
  output logic        RegWW,
  output logic        MemToRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW
`ifdef ALIGN_CHECK_EN
  ,
  output logic        MisalignW
`endif
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LOAD_LATENCY > 1) ? CNT_W'(LOAD_LATENCY - 2) : '0;

  dmem_state_e       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       rd_data;
  logic              misalign;
  logic              is_load;
  logic              is_store;
  logic              wr_en;
  logic              stall_raw;

  // Byte address bits above the RAM size are dropped, so addresses wrap.
  assign word_addr = ALUOutM[ADDR_W+1:2];

`ifdef ALIGN_CHECK_EN
  assign misalign = (MemToRegM | MemWriteM) & (ALUOutM[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A store wins over a simultaneous load request; misaligned accesses never
  // touch the RAM and never stall.
  assign is_store = MemWriteM & ~misalign;
  assign is_load  = MemToRegM & ~MemWriteM & ~misalign;
  assign wr_en    = (state == IDLE) & is_store;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .addr  (word_addr),
    .wdata (WriteDataM),
    .rdata (rd_data)
  );

  // Load sequencer state and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and raw stall decode for the load sequencer.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_raw  = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_load) begin
          stall_raw = 1'b1;
          if (LOAD_LATENCY > 1) begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (cnt == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Reset must hold StallM low even if a load is presented during reset.
  assign StallM = stall_raw & reset;

  // MEM/WB register: bubble while stalled, load result in DONE, else pass-through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWW     <= 1'b0;
      MemToRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
    end else if (StallM) begin
      RegWW     <= 1'b0;
      MemToRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
    end else if (state == DONE) begin
      RegWW     <= RegWM;
      MemToRegW <= MemToRegM;
      ReadDataW <= rd_data;
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
    end else begin
      // A misaligned load reaches here without stalling; block its write-back.
      RegWW     <= RegWM & ~(misalign & MemToRegM & ~MemWriteM);
      MemToRegW <= MemToRegM & ~MemWriteM;
      ReadDataW <= '0;
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
    end
  end

`ifdef ALIGN_CHECK_EN
  // Misalignment flag travels with the rest of the MEM/WB register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MisalignW <= 1'b0;
    end else if (StallM) begin
      MisalignW <= 1'b0;
    end else begin
      MisalignW <= misalign;
    end
  end
`endif

endmodule
`default_nettype wire
